ascon_subst_layer: RTL



---
 rtl/ascon_pkg.sv | 47 ++++
 rtl/ascon_subst_layer_sbox.sv | 30 +++
 rtl/ascon_subst_layer.sv | 116 +++++++++++
 3 files changed

// File: rtl/ascon_pkg.sv
// ============================================================================
//  Module      : ascon_pkg
//  Description : Shared types, constants and column helpers for the ASCON
//                substitution layer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ascon_pkg;

  localparam int ASCON_WORD_W    = 64;
  localparam int ASCON_NUM_WORDS = 5;
  localparam int ASCON_STATE_W   = 320;
  localparam int ASCON_NUM_COLS  = 64;

  typedef logic [ASCON_WORD_W-1:0] ascon_word_t;

  // Element 0 is x0 and sits in the most significant 64 bits.
  typedef ascon_word_t [0:ASCON_NUM_WORDS-1] ascon_state_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } subst_fsm_t;

  // Column j as a 5-bit sbox operand, x0 in the MSB.
  function automatic logic [4:0] col_get(input ascon_state_t s, input logic [5:0] j);
    return {s[0][j], s[1][j], s[2][j], s[3][j], s[4][j]};
  endfunction

  // Write a 5-bit sbox result back into column j, x0 from the MSB.
  function automatic ascon_state_t col_put(input ascon_state_t s, input logic [5:0] j,
                                           input logic [4:0] c);
    ascon_state_t r;
    r       = s;
    r[0][j] = c[4];
    r[1][j] = c[3];
    r[2][j] = c[2];
    r[3][j] = c[1];
    r[4][j] = c[0];
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ascon_subst_layer_sbox.sv
// ============================================================================
//  Module      : sbox
//  Description : ASCON 5-bit substitution box, purely combinational lookup.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sbox (
  input  logic [4:0] x_i,
  output logic [4:0] y_o
);

  // Fixed ASCON sbox table indexed by the column value.
  always_comb begin
    case (x_i)
      5'h00: y_o = 5'h04;  5'h01: y_o = 5'h0b;  5'h02: y_o = 5'h1f;  5'h03: y_o = 5'h14;
      5'h04: y_o = 5'h1a;  5'h05: y_o = 5'h15;  5'h06: y_o = 5'h09;  5'h07: y_o = 5'h02;
      5'h08: y_o = 5'h1b;  5'h09: y_o = 5'h05;  5'h0a: y_o = 5'h08;  5'h0b: y_o = 5'h12;
      5'h0c: y_o = 5'h1d;  5'h0d: y_o = 5'h03;  5'h0e: y_o = 5'h06;  5'h0f: y_o = 5'h1c;
      5'h10: y_o = 5'h1e;  5'h11: y_o = 5'h13;  5'h12: y_o = 5'h07;  5'h13: y_o = 5'h0e;
      5'h14: y_o = 5'h00;  5'h15: y_o = 5'h0d;  5'h16: y_o = 5'h11;  5'h17: y_o = 5'h18;
      5'h18: y_o = 5'h10;  5'h19: y_o = 5'h0c;  5'h1a: y_o = 5'h01;  5'h1b: y_o = 5'h19;
      5'h1c: y_o = 5'h16;  5'h1d: y_o = 5'h0a;  5'h1e: y_o = 5'h0f;
      default: y_o = 5'h17;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/ascon_subst_layer.sv
// ============================================================================
//  Module      : ascon_subst_layer
//  Description : Iterative ASCON substitution layer. SBOX_PAR columns of the
//                320-bit state are substituted in place per cycle; start/done
//                handshake toward the round controller.
//  Options     : ASCON_SUBST_CONST_EN - adds round_const_i, XORed into x2 at
//                load so the constant addition is folded into the capture.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ascon_subst_layer
  import ascon_pkg::*;
#(
  parameter int SBOX_PAR = 8
) (
  input  logic                     clock_i,
  input  logic                     reset_i,
  input  logic                     start_i,
  input  logic [ASCON_STATE_W-1:0] state_i,
`ifdef ASCON_SUBST_CONST_EN
  input  logic [7:0]               round_const_i,
`endif
  output logic                     busy_o,
  output logic                     done_o,
  output logic [ASCON_STATE_W-1:0] state_o
);

  localparam int NUM_SLICES = ASCON_NUM_COLS / SBOX_PAR;
  localparam int CNT_W      = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
  localparam int IDX_W      = $clog2(ASCON_NUM_COLS);
  localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(NUM_SLICES - 1);

  if (!(SBOX_PAR == 1 || SBOX_PAR == 2 || SBOX_PAR == 4 || SBOX_PAR == 8 ||
        SBOX_PAR == 16 || SBOX_PAR == 32 || SBOX_PAR == 64)) begin : g_bad_par
    $error("ascon_subst_layer: SBOX_PAR must be a power of two from 1 to 64");
  end

  subst_fsm_t       fsm_q, fsm_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  ascon_state_t     st_q, st_d;
  ascon_state_t     load_w;
  logic [IDX_W-1:0] base_idx;
  logic [4:0]       sbox_in  [SBOX_PAR];
  logic [4:0]       sbox_out [SBOX_PAR];

  // Value captured on an accepted start, optionally with the round constant in x2.
  always_comb begin
    load_w = state_i;
`ifdef ASCON_SUBST_CONST_EN
    load_w[2] = load_w[2] ^ {56'h0, round_const_i};
`endif
  end

  // Gather the current slice of columns straight from the state register.
  always_comb begin
    base_idx = IDX_W'(int'(cnt_q) * SBOX_PAR);
    for (int i = 0; i < SBOX_PAR; i++) begin
      sbox_in[i] = col_get(st_q, base_idx + IDX_W'(i));
    end
  end

  for (genvar g = 0; g < SBOX_PAR; g++) begin : g_sbox
    sbox u_sbox (
      .x_i (sbox_in[g]),
      .y_o (sbox_out[g])
    );
  end

  // Next-state logic: load on start, scatter one slice per RUN cycle, one DONE cycle.
  always_comb begin
    fsm_d = fsm_q;
    cnt_d = cnt_q;
    st_d  = st_q;
    case (fsm_q)
      IDLE: begin
        if (start_i) begin
          st_d  = load_w;
          cnt_d = '0;
          fsm_d = RUN;
        end
      end
      RUN: begin
        for (int i = 0; i < SBOX_PAR; i++) begin
          st_d = col_put(st_d, base_idx + IDX_W'(i), sbox_out[i]);
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_SLICE) begin
          fsm_d = DONE;
        end
      end
      DONE:    fsm_d = IDLE;
      default: fsm_d = IDLE;
    endcase
  end

  // State, counter and FSM registers with synchronous reset.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      fsm_q <= IDLE;
      cnt_q <= '0;
      st_q  <= '0;
    end else begin
      fsm_q <= fsm_d;
      cnt_q <= cnt_d;
      st_q  <= st_d;
    end
  end

  assign busy_o  = (fsm_q != IDLE);
  assign done_o  = (fsm_q == DONE);
  assign state_o = st_q;

endmodule

`default_nettype wire
